// File: rtl/tug_round_ctrl_pkg.sv
// Shared types and constants for the tug-of-war round controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tug_round_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET,
        S_IDLE,
        S_WAIT,
        S_ARM,
        S_GO,
        S_FOUL,
        S_ROUND,
        S_GAME,
        S_VICT
    } state_t;

    localparam logic [3:0] LC_RESET = 4'b0001;
    localparam logic [3:0] LC_IDLE  = 4'b0101;
    localparam logic [3:0] LC_WAIT  = 4'b0010;
    localparam logic [3:0] LC_ARM   = 4'b0000;
    localparam logic [3:0] LC_GO    = 4'b0011;
    localparam logic [3:0] LC_FOUL  = 4'b0100;
    localparam logic [3:0] LC_ROUND = 4'b0011;
    localparam logic [3:0] LC_GAME  = 4'b0111;
    localparam logic [3:0] LC_VICT  = 4'b1000;

    localparam int unsigned DEF_RESET_TICKS = 4;
    localparam int unsigned DEF_WAIT_TICKS  = 8;
    localparam int unsigned DEF_SHOW_TICKS  = 6;
    localparam int unsigned DEF_GO_TICKS    = 16;

    localparam logic [2:0] POS_MIN    = 3'd0;
    localparam logic [2:0] POS_MAX    = 3'd6;
    localparam logic [2:0] POS_CENTER = 3'd3;

    localparam logic [6:0] SCORE_GO = 7'b0001000;
    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b10;
    localparam logic [1:0] WIN_RIGHT = 2'b01;

    // Everything that must survive across phases, registered as one record.
    typedef struct packed {
        logic [2:0] pos;
        logic [6:0] score;
        logic [6:0] fake_score;
        logic [1:0] winner;
        logic [4:0] arm_len;
    } round_t;

    localparam round_t ROUND_RST = '{
        pos:        POS_CENTER,
        score:      7'b0000000,
        fake_score: 7'b0000000,
        winner:     WIN_NONE,
        arm_len:    5'd1
    };

    // Left press lights the MSB, right press the LSB, both light both.
    function automatic logic [6:0] press_pattern(input logic l, input logic r);
        return {l, 5'b00000, r};
    endfunction

    // One step up or down; a tie (both or neither) holds, and the ends saturate.
    function automatic logic [2:0] rope_step(input logic [2:0] pos, input logic up, input logic down);
        logic [2:0] nxt;
        nxt = pos;
        if (up && !down && pos != POS_MAX) begin
            nxt = pos + 3'd1;
        end else if (down && !up && pos != POS_MIN) begin
            nxt = pos - 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/tug_lfsr4.sv
// 4-bit maximal-length LFSR (x^4+x^3+1), period 15, never 0000.
// Latency: advances every clk; reset value 0001.
// Backpressure: none, free-running.
module tug_lfsr4 (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 4'b0001;
        end else begin
            q <= {q[2:0], q[3] ^ q[2]};
        end
    end

endmodule

// File: rtl/tug_round_ctrl.sv
// Tug-of-war round controller: reset/idle/wait/arm/go/result phases plus rope position.
// Latency: presses and ticks take effect on the next clk edge; led_control decodes state directly.
// Backpressure: none; presses outside accepting phases are dropped.
module tug_round_ctrl
    import tug_round_ctrl_pkg::*;
#(
    parameter int unsigned RESET_TICKS = DEF_RESET_TICKS,
    parameter int unsigned WAIT_TICKS  = DEF_WAIT_TICKS,
    parameter int unsigned SHOW_TICKS  = DEF_SHOW_TICKS,
    parameter int unsigned GO_TICKS    = DEF_GO_TICKS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_l,
    input  logic       btn_r,
    output logic [3:0] led_control,
    output logic [6:0] score,
    output logic [6:0] fake_score,
    output logic [6:0] game_LED,
    output logic [1:0] winner
);

    state_t     state_q, state_d;
    round_t     rnd_q, rnd_d;
    logic [7:0] cnt_q;
    logic [7:0] limit;
    logic [3:0] lfsr_val;
    logic       press;
    logic       tick_done;

    tug_lfsr4 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_val)
    );

    assign press = btn_l | btn_r;

    always_comb begin
        limit = 8'hFF;
        case (state_q)
            S_RESET:                limit = 8'(RESET_TICKS);
            S_WAIT:                 limit = 8'(WAIT_TICKS);
            S_ARM:                  limit = {3'b000, rnd_q.arm_len};
            S_GO:                   limit = 8'(GO_TICKS);
            S_FOUL, S_ROUND, S_GAME: limit = 8'(SHOW_TICKS);
            default:                limit = 8'hFF;
        endcase
    end

    assign tick_done = tick && ((cnt_q + 8'd1) == limit);

    // Presses are tested ahead of tick_done so a press on a tick cycle wins.
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        case (state_q)
            S_RESET: begin
                if (tick_done) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (press) state_d = S_WAIT;
            end
            S_WAIT, S_ARM: begin
                if (press) begin
                    state_d          = S_FOUL;
                    rnd_d.fake_score = press_pattern(btn_l, btn_r);
                    rnd_d.pos        = rope_step(rnd_q.pos, btn_r, btn_l);
                end else if (tick_done) begin
                    if (state_q == S_WAIT) begin
                        state_d       = S_ARM;
                        rnd_d.arm_len = {1'b0, lfsr_val} + 5'd1;
                    end else begin
                        state_d     = S_GO;
                        rnd_d.score = SCORE_GO;
                    end
                end
            end
            S_GO: begin
                if (press) begin
                    state_d     = S_ROUND;
                    rnd_d.score = press_pattern(btn_l, btn_r);
                    rnd_d.pos   = rope_step(rnd_q.pos, btn_l, btn_r);
                end else if (tick_done) begin
                    state_d = S_WAIT;
                end
            end
            S_FOUL, S_ROUND: begin
                if (tick_done) state_d = S_GAME;
            end
            S_GAME: begin
                if (tick_done) begin
                    if (rnd_q.pos == POS_MAX) begin
                        state_d      = S_VICT;
                        rnd_d.winner = WIN_LEFT;
                    end else if (rnd_q.pos == POS_MIN) begin
                        state_d      = S_VICT;
                        rnd_d.winner = WIN_RIGHT;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_VICT: begin
                state_d = S_VICT;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RESET;
            rnd_q   <= ROUND_RST;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            if (state_d != state_q) begin
                cnt_q <= 8'd0;
            end else if (tick) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        led_control = LC_RESET;
        case (state_q)
            S_RESET: led_control = LC_RESET;
            S_IDLE:  led_control = LC_IDLE;
            S_WAIT:  led_control = LC_WAIT;
            S_ARM:   led_control = LC_ARM;
            S_GO:    led_control = LC_GO;
            S_FOUL:  led_control = LC_FOUL;
            S_ROUND: led_control = LC_ROUND;
            S_GAME:  led_control = LC_GAME;
            S_VICT:  led_control = LC_VICT;
            default: led_control = LC_RESET;
        endcase
    end

    assign score      = rnd_q.score;
    assign fake_score = rnd_q.fake_score;
    assign winner     = rnd_q.winner;
    assign game_LED   = 7'b0000001 << rnd_q.pos;

endmodule

// File: tb/tb_tug_round_ctrl.sv
// Bench for tug_round_ctrl: directed scenarios plus random presses/ticks against a phase model.
module tb_tug_round_ctrl;

    localparam int RT = 4;
    localparam int WT = 8;
    localparam int ST = 6;
    localparam int GT = 16;

    localparam int P_RESET = 0;
    localparam int P_IDLE  = 1;
    localparam int P_WAIT  = 2;
    localparam int P_ARM   = 3;
    localparam int P_GO    = 4;
    localparam int P_FOUL  = 5;
    localparam int P_ROUND = 6;
    localparam int P_GAME  = 7;
    localparam int P_VICT  = 8;

    logic       clk = 1'b0;
    logic       rst, tick, btn_l, btn_r;
    logic [3:0] led_control;
    logic [6:0] score, fake_score, game_LED;
    logic [1:0] winner;

    int n_chk = 0;
    int n_err = 0;

    // Model: current phase, ticks remaining in it, and the visible results.
    int m_ph, m_left, m_pos, m_score, m_fake, m_win, m_lfsr;
    int lc_tab [9] = '{1, 5, 2, 0, 3, 4, 3, 7, 8};

    tug_round_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .btn_l       (btn_l),
        .btn_r       (btn_r),
        .led_control (led_control),
        .score       (score),
        .fake_score  (fake_score),
        .game_LED    (game_LED),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int clampi(input int v);
        return (v < 0) ? 0 : ((v > 6) ? 6 : v);
    endfunction

    task automatic enter(input int ph, input int dur);
        m_ph   = ph;
        m_left = dur;
    endtask

    task automatic model_update(input logic r, input logic t, input logic bl, input logic br);
        int cur;
        if (r) begin
            enter(P_RESET, RT);
            m_pos = 3; m_score = 0; m_fake = 0; m_win = 0; m_lfsr = 1;
            return;
        end
        cur    = m_lfsr;
        m_lfsr = ((m_lfsr << 1) & 15) | (((m_lfsr >> 3) ^ (m_lfsr >> 2)) & 1);
        case (m_ph)
            P_RESET, P_FOUL, P_ROUND, P_GAME: begin
                if (t) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        if (m_ph == P_RESET) enter(P_IDLE, 0);
                        else if (m_ph != P_GAME) enter(P_GAME, ST);
                        else if (m_pos == 6) begin m_win = 2; enter(P_VICT, 0); end
                        else if (m_pos == 0) begin m_win = 1; enter(P_VICT, 0); end
                        else enter(P_WAIT, WT);
                    end
                end
            end
            P_IDLE: if (bl || br) enter(P_WAIT, WT);
            P_WAIT, P_ARM: begin
                if (bl || br) begin
                    m_fake = (bl ? 64 : 0) + (br ? 1 : 0);
                    m_pos  = clampi(m_pos + (br ? 1 : 0) - (bl ? 1 : 0));
                    enter(P_FOUL, ST);
                end else if (t) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        if (m_ph == P_WAIT) enter(P_ARM, cur + 1);
                        else begin m_score = 8; enter(P_GO, GT); end
                    end
                end
            end
            P_GO: begin
                if (bl || br) begin
                    m_score = (bl ? 64 : 0) + (br ? 1 : 0);
                    m_pos   = clampi(m_pos + (bl ? 1 : 0) - (br ? 1 : 0));
                    enter(P_ROUND, ST);
                end else if (t) begin
                    m_left = m_left - 1;
                    if (m_left == 0) enter(P_WAIT, WT);
                end
            end
            default: ;
        endcase
    endtask

    task automatic step(input logic r, input logic t, input logic bl, input logic br);
        rst = r; tick = t; btn_l = bl; btn_r = br;
        @(posedge clk);
        model_update(r, t, bl, br);
        @(negedge clk);
        chk("led_control", led_control, lc_tab[m_ph]);
        chk("score", score, m_score);
        chk("fake_score", fake_score, m_fake);
        chk("game_LED", game_LED, 32'd1 << m_pos);
        chk("winner", winner, m_win);
    endtask

    task automatic run_to(input int ph);
        int n = 0;
        while (m_ph != ph && n < 400) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            n++;
        end
        chk("phase_timeout", (n < 400), 1);
        chk("phase_led", led_control, lc_tab[ph]);
    endtask

    task automatic reset_to_idle();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (RT) step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int pp;
        rst = 1'b1; tick = 1'b0; btn_l = 1'b0; btn_r = 1'b0;

        // Reset values, then RESET_TICKS ticks to idle.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst_led", led_control, 4'b0001);
        chk("rst_rope", game_LED, 7'b0001000);
        chk("rst_score", score, 7'b0000000);
        repeat (RT - 1) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("reset_hold_led", led_control, 4'b0001);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("idle_led", led_control, 4'b0101);

        // Right player fouls during wait.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("wait_led", led_control, 4'b0010);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("foul_led", led_control, 4'b0100);
        chk("foul_pattern", fake_score, 7'b0000001);
        chk("foul_rope", game_LED, 7'b0010000);

        // Left wins a round from center.
        reset_to_idle();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        run_to(P_GO);
        chk("go_light", score, 7'b0001000);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("left_score", score, 7'b1000000);
        repeat (ST) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("left_rope", game_LED, 7'b0010000);
        chk("game_led", led_control, 4'b0111);

        // Simultaneous press in go: no rope move.
        run_to(P_GO);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("tie_score", score, 7'b1000001);
        chk("tie_rope", game_LED, 7'b0010000);

        // Press landing on a tick in arm is still a foul; double foul keeps rope.
        run_to(P_ARM);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("tick_foul_led", led_control, 4'b0100);
        chk("dbl_foul_pat", fake_score, 7'b1000001);
        chk("dbl_foul_rope", game_LED, 7'b0010000);

        // Reset mid-arm, then a go timeout.
        reset_to_idle();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        run_to(P_ARM);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("midrst_led", led_control, 4'b0001);
        chk("midrst_rope", game_LED, 7'b0001000);
        chk("midrst_score", score, 7'b0000000);
        chk("midrst_fake", fake_score, 7'b0000000);
        chk("midrst_win", winner, 2'b00);
        repeat (RT) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        run_to(P_GO);
        repeat (GT) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("timeout_led", led_control, 4'b0010);
        chk("timeout_rope", game_LED, 7'b0001000);

        // Three left wins reach victory; later presses are ignored.
        reset_to_idle();
        step(1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            run_to(P_GO);
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
        run_to(P_VICT);
        chk("vict_led", led_control, 4'b1000);
        chk("vict_win", winner, 2'b10);
        chk("vict_rope", game_LED, 7'b1000000);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        chk("vict_hold_led", led_control, 4'b1000);
        chk("vict_hold_win", winner, 2'b10);

        // Random play: busy presses first, then sparse presses.
        reset_to_idle();
        for (int i = 0; i < 3000; i++) begin
            pp = (i < 1500) ? 10 : 50;
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, pp - 1) == 0),
                 ($urandom_range(0, pp - 1) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
